vic_nested: RTL and testbench

//  Parametrised nested vectored interrupt controller; successor of the flat single-level VIC.

---
 rtl/vic_nested_pkg.sv | 36 +++
 rtl/vic_prio_arbiter.sv | 35 +++
 rtl/vic_nested.sv | 201 ++++++++++++++++++++
 tb/tb_vic_nested.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vic_nested_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vic_nested_pkg                                         |
// | Description : Shared types and constants for the nested VIC          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package vic_nested_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VEC  = 2'd1,
    S_RET  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_RISE  = 2'b01;
  localparam logic [1:0] MODE_FALL  = 2'b10;
  localparam logic [1:0] MODE_BOTH  = 2'b11;

  localparam int CTRL_ADDR   = 0;
  localparam int STATUS_ADDR = 1;
  localparam int SRC_BASE    = 2;

  // Edge event for one source given its detect mode; level mode never produces one.
  function automatic logic edge_hit(input logic [1:0] mode, input logic prev, input logic now);
    case (mode)
      MODE_RISE: edge_hit = !prev && now;
      MODE_FALL: edge_hit = prev && !now;
      MODE_BOTH: edge_hit = prev ^ now;
      default:   edge_hit = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vic_prio_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vic_prio_arbiter                                       |
// | Description : Highest-priority pick among masked requests; ties go   |
// |               to the lowest source index                             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vic_prio_arbiter #(
  parameter int N_SRC  = 31,
  parameter int PRIO_W = 3,
  parameter int IDX_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*PRIO_W-1:0] prio,
  output logic                    valid,
  output logic [IDX_W-1:0]        idx,
  output logic [PRIO_W-1:0]       best_prio
);

  // Linear scan; strict '>' keeps the earliest index on equal priority.
  always_comb begin
    valid     = 1'b0;
    idx       = '0;
    best_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req[i] && (!valid || (prio[i*PRIO_W +: PRIO_W] > best_prio))) begin
        valid     = 1'b1;
        idx       = IDX_W'(i);
        best_prio = prio[i*PRIO_W +: PRIO_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vic_nested.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : vic_nested                                             |
// | Description : Nested vectored interrupt controller with per-source   |
// |               priority, preemption and a {PC,CCodes,prio} save stack |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module vic_nested
  import vic_nested_pkg::*;
#(
  parameter int          N_SRC      = 31,
  parameter int          PRIO_W     = 3,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd4,
  parameter int          DATA_W     = 8,
  parameter int          ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       i_PC,
  input  logic [3:0]        i_CCodes,
  input  logic              i_NOT_FLUSH,
  input  logic              FlushPipeAndPC,
  input  logic              i_reti,
  input  logic [N_SRC-1:0]  i_ext,
  input  logic [ADDR_W-1:0] i_VIC_regaddr,
  input  logic [DATA_W-1:0] i_VIC_data,
  input  logic              i_VIC_we,
  output logic [DATA_W-1:0] o_VIC_data,
  output logic [31:0]       o_VIC_iaddr,
  output logic              o_VIC_ctrl,
  output logic [3:0]        o_CCodes,
  output logic              o_VIC_CCodes_ctrl
);

  localparam int IDX_W   = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DEPTH_W = $clog2(NEST_DEPTH + 1);
  localparam int PTR_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic                    global_en, err;
  logic [N_SRC-1:0]        src_en, ext_prev, edge_pend, edge_now, pend, req, src_hit;
  logic [1:0]              src_mode [N_SRC];
  logic [PRIO_W-1:0]       src_prio [N_SRC];
  logic [N_SRC*PRIO_W-1:0] prio_flat;
  logic [DEPTH_W-1:0]      depth;
  logic [PRIO_W-1:0]       cur_prio, cand_prio;
  logic [IDX_W-1:0]        cand_idx;
  logic                    cand_valid, accept, do_pop, reti_err, ctrl_we;
  logic [31:0]             stk_pc   [NEST_DEPTH];
  logic [3:0]              stk_cc   [NEST_DEPTH];
  logic [PRIO_W-1:0]       stk_prio [NEST_DEPTH];
  logic [PTR_W-1:0]        push_idx, pop_idx;
  state_t                  state, state_nx;
  logic                    unused_data;

  assign unused_data = ^i_VIC_data;
  assign ctrl_we     = i_VIC_we && (i_VIC_regaddr == ADDR_W'(CTRL_ADDR));
  assign push_idx    = PTR_W'(depth);
  assign pop_idx     = PTR_W'(depth - 1'b1);

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign prio_flat[g*PRIO_W +: PRIO_W] = src_prio[g];
    assign edge_now[g] = edge_hit(src_mode[g], ext_prev[g], i_ext[g]);
    assign pend[g]     = (src_mode[g] == MODE_LEVEL) ? i_ext[g] : (edge_pend[g] | edge_now[g]);
    assign req[g]      = src_en[g] && pend[g] && (src_prio[g] > cur_prio);
    assign src_hit[g]  = i_VIC_we && (i_VIC_regaddr == ADDR_W'(SRC_BASE + g));
  end

  vic_prio_arbiter #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W),
    .IDX_W  (IDX_W)
  ) u_arb (
    .req       (req),
    .prio      (prio_flat),
    .valid     (cand_valid),
    .idx       (cand_idx),
    .best_prio (cand_prio)
  );

  // Next-state logic: reti takes precedence over a pending candidate.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    do_pop   = 1'b0;
    reti_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_reti) begin
          if (depth != '0) begin
            do_pop   = 1'b1;
            state_nx = S_RET;
          end else begin
            reti_err = 1'b1;
          end
        end else if (global_en && cand_valid && (depth < DEPTH_W'(NEST_DEPTH)) &&
                     i_NOT_FLUSH && !FlushPipeAndPC) begin
          accept   = 1'b1;
          state_nx = S_VEC;
        end
      end
      S_VEC, S_RET: state_nx = S_WAIT;
      S_WAIT:       if (i_NOT_FLUSH) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Config registers, edge capture, nesting depth and current priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      global_en <= 1'b0;
      err       <= 1'b0;
      src_en    <= '0;
      ext_prev  <= '0;
      edge_pend <= '0;
      depth     <= '0;
      cur_prio  <= '0;
      for (int k = 0; k < N_SRC; k++) begin
        src_mode[k] <= MODE_LEVEL;
        src_prio[k] <= '0;
      end
    end else begin
      if (ctrl_we) begin
        global_en <= i_VIC_data[0];
        if (i_VIC_data[1]) err <= 1'b0;
      end
      if (reti_err) err <= 1'b1;
      ext_prev <= i_ext;
      for (int k = 0; k < N_SRC; k++) begin
        if (src_hit[k]) begin
          src_en[k]   <= i_VIC_data[0];
          src_mode[k] <= i_VIC_data[2:1];
          src_prio[k] <= i_VIC_data[PRIO_W+2:3];
        end
        if (src_mode[k] == MODE_LEVEL)
          edge_pend[k] <= 1'b0;
        else if (accept && (cand_idx == IDX_W'(k)))
          edge_pend[k] <= 1'b0;
        else
          edge_pend[k] <= edge_pend[k] | edge_now[k];
      end
      if (accept) begin
        depth    <= depth + 1'b1;
        cur_prio <= cand_prio;
      end else if (do_pop) begin
        depth    <= depth - 1'b1;
        cur_prio <= stk_prio[pop_idx];
      end
    end
  end

  // Save stack; contents are meaningful only below depth, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      stk_pc[push_idx]   <= i_PC;
      stk_cc[push_idx]   <= i_CCodes;
      stk_prio[push_idx] <= cur_prio;
    end
  end

  // Registered redirect outputs; strobes are high only for the VEC/RET cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_VIC_ctrl        <= 1'b0;
      o_VIC_CCodes_ctrl <= 1'b0;
      o_VIC_iaddr       <= '0;
      o_CCodes          <= '0;
    end else begin
      o_VIC_ctrl        <= accept | do_pop;
      o_VIC_CCodes_ctrl <= do_pop;
      if (accept) begin
        o_VIC_iaddr <= VEC_BASE + (32'(cand_idx) * VEC_STRIDE);
      end else if (do_pop) begin
        o_VIC_iaddr <= stk_pc[pop_idx];
        o_CCodes    <= stk_cc[pop_idx];
      end
    end
  end

  // Combinational register read-back.
  always_comb begin
    o_VIC_data = '0;
    if (i_VIC_regaddr == ADDR_W'(CTRL_ADDR))
      o_VIC_data = DATA_W'({err, global_en});
    else if (i_VIC_regaddr == ADDR_W'(STATUS_ADDR))
      o_VIC_data = DATA_W'({depth, cur_prio});
    for (int k = 0; k < N_SRC; k++) begin
      if (i_VIC_regaddr == ADDR_W'(SRC_BASE + k))
        o_VIC_data = DATA_W'({src_prio[k], src_mode[k], src_en[k]});
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vic_nested.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_vic_nested                                          |
// | Description : Scoreboard bench for vic_nested with a behavioural     |
// |               reference model and randomized stimulus                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_vic_nested;

  localparam int          N  = 31;
  localparam int          PW = 3;
  localparam int          ND = 4;
  localparam int          DW = 8;
  localparam int          AW = 7;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'd4;

  logic          clk = 1'b0;
  logic          rst, nf, fl, reti, we;
  logic [31:0]   pc;
  logic [3:0]    cc;
  logic [N-1:0]  ext;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic [31:0]   iaddr;
  logic          vctrl, ccctrl;
  logic [3:0]    occ;

  vic_nested #(
    .N_SRC(N), .PRIO_W(PW), .NEST_DEPTH(ND), .VEC_BASE(VB),
    .VEC_STRIDE(VS), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .i_PC(pc), .i_CCodes(cc), .i_NOT_FLUSH(nf),
    .FlushPipeAndPC(fl), .i_reti(reti), .i_ext(ext), .i_VIC_regaddr(addr),
    .i_VIC_data(wdata), .i_VIC_we(we), .o_VIC_data(rdata), .o_VIC_iaddr(iaddr),
    .o_VIC_ctrl(vctrl), .o_CCodes(occ), .o_VIC_CCodes_ctrl(ccctrl)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [3:0] cc; int pr; } frame_t;
  typedef struct { int tag; logic ctrl; logic [31:0] ia; logic [3:0] cc; logic ccc; logic full; } exp_t;
  typedef struct { int tag; int a; logic [7:0] val; } rd_t;

  int checks = 0, errors = 0, nred = 0, cyc = 0;
  exp_t expq[$];
  rd_t  rdq[$];

  // Reference model: architectural state only, stack as a queue of frames.
  logic   m_gen, m_err, model_valid = 1'b0;
  logic   m_en[N], m_prev[N], m_stick[N];
  int     m_mode[N], m_prio[N];
  int     m_cur, m_phase;   // phase: 0 free, 1 redirect cycle, 2 awaiting valid instruction
  frame_t stk[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic bit edge_of(input int mode, input bit p, input bit n);
    case (mode)
      1:       return !p && n;
      2:       return p && !n;
      3:       return p != n;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a == 0) return {6'd0, m_err, m_gen};
    if (a == 1) return 8'(stk.size() * 8 + m_cur);
    if (a >= 2 && a < 2 + N) return 8'(m_prio[a-2] * 8 + m_mode[a-2] * 2 + (m_en[a-2] ? 1 : 0));
    return 8'd0;
  endfunction

  task automatic push_exp(input int t, input logic c, input logic [31:0] ia,
                          input logic [3:0] cv, input logic ccv, input logic full);
    exp_t e;
    e.tag = t; e.ctrl = c; e.ia = ia; e.cc = cv; e.ccc = ccv; e.full = full;
    expq.push_back(e);
  endtask

  task automatic m_reset();
    m_gen = 1'b0; m_err = 1'b0; m_cur = 0; m_phase = 0;
    stk.delete();
    for (int i = 0; i < N; i++) begin
      m_en[i] = 1'b0; m_mode[i] = 0; m_prio[i] = 0; m_prev[i] = 1'b0; m_stick[i] = 1'b0;
    end
  endtask

  // Predict the effect of the coming clock edge given the inputs now applied.
  task automatic m_step();
    int best, bp, acc;
    bit err_set;
    bit ed[N];
    frame_t f;
    if (rst) begin
      m_reset();
      push_exp(cyc + 1, 1'b0, 32'd0, 4'd0, 1'b0, 1'b1);
      model_valid = 1'b1;
      return;
    end
    best = -1; bp = 0; acc = -1; err_set = 1'b0;
    for (int i = 0; i < N; i++) begin
      bit p;
      ed[i] = edge_of(m_mode[i], m_prev[i], ext[i]);
      p = (m_mode[i] == 0) ? ext[i] : (m_stick[i] | ed[i]);
      if (m_en[i] && p && m_prio[i] > m_cur && m_prio[i] > bp) begin
        best = i; bp = m_prio[i];
      end
    end
    if (m_phase == 0 && reti) begin
      if (stk.size() > 0) begin
        f = stk.pop_back();
        m_cur = f.pr; m_phase = 1;
        push_exp(cyc + 1, 1'b1, f.pc, f.cc, 1'b1, 1'b0);
      end else begin
        err_set = 1'b1;
      end
    end else if (m_phase == 0 && m_gen && best >= 0 && stk.size() < ND && nf && !fl) begin
      f.pc = pc; f.cc = cc; f.pr = m_cur;
      stk.push_back(f);
      m_cur = bp; acc = best; m_phase = 1;
      push_exp(cyc + 1, 1'b1, VB + 32'(best) * VS, 4'd0, 1'b0, 1'b0);
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2 && nf) begin
      m_phase = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (m_mode[i] == 0 || i == acc) m_stick[i] = 1'b0;
      else                            m_stick[i] = m_stick[i] | ed[i];
      m_prev[i] = ext[i];
    end
    if (we) begin
      if (int'(addr) == 0) begin
        m_gen = wdata[0];
        if (wdata[1]) m_err = 1'b0;
      end else if (int'(addr) >= 2 && int'(addr) < 2 + N) begin
        m_en[int'(addr)-2]   = wdata[0];
        m_mode[int'(addr)-2] = int'(wdata[2:1]);
        m_prio[int'(addr)-2] = int'(wdata[5:3]);
      end
    end
    if (err_set) m_err = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0; reti = 1'b0; rst = 1'b0; fl = 1'b0; nf = 1'b1;
  endtask

  task automatic step();
    rd_t r;
    if (model_valid) begin
      r.tag = cyc; r.a = int'(addr); r.val = m_read(int'(addr));
      rdq.push_back(r);
    end
    m_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin tick(); step(); end
  endtask

  task automatic wr(input int a, input int d);
    tick(); we = 1'b1; addr = AW'(a); wdata = DW'(d); step();
  endtask

  task automatic do_reti();
    tick(); reti = 1'b1; pc = $urandom; step();
  endtask

  // Monitor: pops expectations whenever their cycle arrives, else expects quiet strobes.
  initial begin
    rd_t  r;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rdq.size() > 0 && rdq[0].tag == cyc) begin
        r = rdq.pop_front();
        checks++;
        if (rdata !== r.val) begin
          errors++;
          $display("FAIL regread addr=%0d got=%h want=%h cyc=%0d", r.a, rdata, r.val, cyc);
        end
      end
      if (cyc >= 2) begin
        checks++;
        if (expq.size() > 0 && expq[0].tag == cyc) begin
          e = expq.pop_front();
          if (vctrl) nred++;
          if (vctrl !== e.ctrl || ccctrl !== e.ccc || iaddr !== e.ia ||
              ((e.ccc || e.full) && occ !== e.cc)) begin
            errors++;
            $display("FAIL redirect cyc=%0d got ctrl=%b ccctrl=%b iaddr=%h cc=%h want ctrl=%b ccctrl=%b iaddr=%h cc=%h",
                     cyc, vctrl, ccctrl, iaddr, occ, e.ctrl, e.ccc, e.ia, e.cc);
          end
        end else if (vctrl !== 1'b0 || ccctrl !== 1'b0) begin
          errors++;
          $display("FAIL quiet cyc=%0d got ctrl=%b ccctrl=%b want 0 0", cyc, vctrl, ccctrl);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; nf = 1'b1; fl = 1'b0; reti = 1'b0; we = 1'b0;
    pc = 32'd0; cc = 4'd0; ext = '0; addr = AW'(1); wdata = '0;
    tick(); rst = 1'b1; step();
    tick(); rst = 1'b1; step();
    idle(2);

    // Basic rising-edge source, vector then return with restored flags.
    wr(0, 1);
    wr(5, 8'h13);
    tick(); addr = AW'(1); pc = 32'h40; cc = 4'hA; ext[3] = 1'b1; step();
    idle(4);
    do_reti(); idle(4);
    ext = '0; idle(1);

    // Nesting: level src7 prio5 preempts src3 prio2; src1 prio2 waits.
    wr(9, 8'h29);
    wr(3, 8'h13);
    tick(); ext[3] = 1'b1; pc = 32'h200; cc = 4'h3; step(); idle(3);
    tick(); ext[7] = 1'b1; ext[1] = 1'b1; pc = 32'h300; cc = 4'h5; step(); idle(4);
    ext[7] = 1'b0;
    do_reti(); idle(4);
    do_reti(); idle(6);
    do_reti(); idle(4);
    ext = '0; idle(2);

    // Stack full: five level sources of rising priority, fifth waits.
    for (int p = 1; p <= 5; p++) wr(12 + p, p * 8 + 1);
    for (int p = 1; p <= 5; p++) begin
      tick(); ext[10 + p] = 1'b1; pc = 32'h1000 + 32'(p * 16); cc = 4'(p); step();
      idle(4);
    end
    do_reti(); idle(5);
    ext = '0;
    for (int i = 0; i < 5; i++) begin do_reti(); idle(4); end

    // Tie on priority 3 between src4 and src9 (rising edge).
    wr(6, 8'h1B);
    wr(11, 8'h1B);
    tick(); ext[4] = 1'b1; ext[9] = 1'b1; step(); idle(4);
    do_reti(); idle(4);
    do_reti(); idle(4);
    ext = '0; idle(1);

    // Guards: flush and bubble block acceptance; reti beats request; reti at depth 0.
    wr(4, 8'h21);
    tick(); ext[2] = 1'b1; fl = 1'b1; step();
    tick(); fl = 1'b1; step();
    tick(); nf = 1'b0; step();
    tick(); nf = 1'b0; step();
    idle(4);
    do_reti(); idle(4);
    ext[2] = 1'b0; idle(1);
    do_reti(); idle(3);
    do_reti();
    tick(); addr = AW'(0); step();
    wr(0, 3);
    idle(1);

    // Reset in the middle of a two-deep nest.
    tick(); ext[3] = 1'b1; addr = AW'(1); step(); idle(4);
    tick(); ext[7] = 1'b1; step(); idle(3);
    tick(); rst = 1'b1; step();
    tick(); addr = AW'(5); step();
    tick(); addr = AW'(1); step();
    ext = '0;
    wr(0, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 19) == 0) begin
        we = 1'b1;
        addr = AW'($urandom_range(0, N + 3));
        wdata = DW'($urandom);
        if (addr == AW'(0)) wdata[0] = ($urandom_range(0, 7) != 0);
      end else begin
        addr = AW'($urandom_range(0, N + 3));
      end
      ext  = ext ^ N'($urandom & $urandom & $urandom & $urandom);
      nf   = ($urandom_range(0, 7) != 0);
      fl   = ($urandom_range(0, 15) == 0);
      reti = (stk.size() > 0) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
      pc   = $urandom;
      cc   = 4'($urandom);
      step();
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", expq.size());
    end
    checks++;
    if (nred < 20) begin
      errors++;
      $display("FAIL activity got=%0d redirects want>=20", nred);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
